// File: rtl/cp_decode_buffer_pkg.sv
// Shared types for the decode buffer: immediate format codes, RV32 opcode
// constants and the stored buffer entry.
package cp_pkg;

  // Widest supported PC; entries always store this many PC bits.
  localparam int CP_XLEN_MAX = 64;

  typedef enum logic [2:0] {
    IMM_R = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5
  } imm_fmt_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [31:0]            instr;
    logic [CP_XLEN_MAX-1:0] pc;
  } cp_entry_t;

endpackage

// File: rtl/cp_decode_buffer_if.sv
// Handshake and decoded-field bundle between the fetch side, the decode
// buffer and its consumer. illegal_o exists only with CP_ILLEGAL_CHECK_EN.
interface cp_decode_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
);
  import cp_pkg::*;

  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [31:0]              instr_data_i;
  logic [XLEN-1:0]          pc_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [XLEN-1:0]          pc_o;
  logic [4:0]               rs1_addr_o;
  logic [4:0]               rs2_addr_o;
  logic [4:0]               rd_addr_o;
  logic [2:0]               func3_o;
  logic [6:0]               func7_o;
  logic [6:0]               opcode_o;
  logic [XLEN-1:0]          imm_o;
  imm_fmt_e                 imm_fmt_o;
  logic [$clog2(DEPTH):0]   count_o;
`ifdef CP_ILLEGAL_CHECK_EN
  logic                     illegal_o;
`endif

  // Buffer side.
  modport slave (
    input  in_valid_i, instr_data_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, rs1_addr_o, rs2_addr_o, rd_addr_o,
           func3_o, func7_o, opcode_o, imm_o, imm_fmt_o, count_o
`ifdef CP_ILLEGAL_CHECK_EN
         , illegal_o
`endif
  );

  // Fetch/consumer side.
  modport master (
    output in_valid_i, instr_data_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, rs1_addr_o, rs2_addr_o, rd_addr_o,
           func3_o, func7_o, opcode_o, imm_o, imm_fmt_o, count_o
`ifdef CP_ILLEGAL_CHECK_EN
         , illegal_o
`endif
  );

endinterface

// File: rtl/cp_decode_buffer_imm_gen.sv
// Combinational RV32 immediate extraction: picks the format from the opcode
// and sign-extends the assembled immediate from instruction bit 31 to XLEN.
module cp_imm_gen
  import cp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output imm_fmt_e        o_imm_fmt
);

  logic [31:0] w_imm32;

  // Format select and 32-bit immediate assembly.
  always_comb begin
    o_imm_fmt = IMM_R;
    w_imm32   = 32'd0;
    case (i_instr[6:0])
      OP_LUI, OP_AUIPC: begin
        o_imm_fmt = IMM_U;
        w_imm32   = {i_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        o_imm_fmt = IMM_J;
        w_imm32   = 32'(signed'({i_instr[31], i_instr[19:12], i_instr[20],
                                 i_instr[30:21], 1'b0}));
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM: begin
        o_imm_fmt = IMM_I;
        w_imm32   = 32'(signed'(i_instr[31:20]));
      end
      OP_STORE: begin
        o_imm_fmt = IMM_S;
        w_imm32   = 32'(signed'({i_instr[31:25], i_instr[11:7]}));
      end
      OP_BRANCH: begin
        o_imm_fmt = IMM_B;
        w_imm32   = 32'(signed'({i_instr[31], i_instr[7], i_instr[30:25],
                                 i_instr[11:8], 1'b0}));
      end
      default: begin
        o_imm_fmt = IMM_R;
        w_imm32   = 32'd0;
      end
    endcase
  end

  assign o_imm = XLEN'(signed'(w_imm32));

endmodule

// File: rtl/cp_decode_buffer.sv
// Decode buffer: DEPTH-entry FIFO of {instr, pc} with combinational field
// decode of the head entry. Optional CP_ILLEGAL_CHECK_EN adds illegal_o.
// in_ready_o depends on occupancy only, so a full buffer never accepts a
// word even when the head is popped in the same cycle.
module cp_decode_buffer
  import cp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic                clk_i,
  input logic                rst_i,
  input logic                flush_i,
  cp_decode_buffer_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  cp_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;
  cp_entry_t       w_head;

  assign bus.in_ready_o  = (r_count < CW'(DEPTH));
  assign bus.out_valid_o = (r_count != '0);
  assign bus.count_o     = r_count;

  assign w_push = bus.in_valid_i && bus.in_ready_o;
  assign w_pop  = bus.out_valid_o && bus.out_ready_i;

  // Pointers and occupancy; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; not reset, and writes are dropped on reset or flush.
  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i && !flush_i) begin
      r_mem[r_wptr] <= '{instr: bus.instr_data_i, pc: CP_XLEN_MAX'(bus.pc_i)};
    end
  end

  assign w_head = r_mem[r_rptr];

  assign bus.pc_o       = w_head.pc[XLEN-1:0];
  assign bus.rs1_addr_o = w_head.instr[19:15];
  assign bus.rs2_addr_o = w_head.instr[24:20];
  assign bus.rd_addr_o  = w_head.instr[11:7];
  assign bus.func3_o    = w_head.instr[14:12];
  assign bus.func7_o    = w_head.instr[31:25];
  assign bus.opcode_o   = w_head.instr[6:0];

  generate
    if (XLEN < CP_XLEN_MAX) begin : g_pc_hi
      logic [CP_XLEN_MAX-XLEN-1:0] w_unused_pc_hi;
      assign w_unused_pc_hi = w_head.pc[CP_XLEN_MAX-1:XLEN];
    end
  endgenerate

  cp_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr   (w_head.instr),
    .o_imm     (bus.imm_o),
    .o_imm_fmt (bus.imm_fmt_o)
  );

`ifdef CP_ILLEGAL_CHECK_EN
  logic w_legal_op;

  // Opcode whitelist for the head instruction.
  always_comb begin
    w_legal_op = 1'b0;
    case (w_head.instr[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM,
      OP_STORE, OP_BRANCH, OP_REG, OP_FENCE: w_legal_op = 1'b1;
      default:                               w_legal_op = 1'b0;
    endcase
  end

  assign bus.illegal_o = (w_head.instr[1:0] != 2'b11) || !w_legal_op;
`endif

endmodule

// File: tb/tb_cp_decode_buffer.sv
// Self-checking bench for cp_decode_buffer (XLEN=32, DEPTH=2): directed
// instruction/flow cases followed by randomized traffic against a queue model.
module tb_cp_decode_buffer;
  import cp_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   total = 0;
  int   bad   = 0;
  ent_t q[$];

  cp_decode_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  cp_decode_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Immediate and format straight from the ISA bit layouts.
  function automatic void ref_dec(input logic [31:0] w, output logic [2:0] fmt,
                                  output logic [31:0] imm);
    case (w[6:0])
      7'b0110111, 7'b0010111: begin fmt = IMM_U; imm = {w[31:12], 12'h000}; end
      7'b1101111: begin
        fmt = IMM_J; imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: begin
        fmt = IMM_I; imm = {{20{w[31]}}, w[31:20]};
      end
      7'b0100011: begin fmt = IMM_S; imm = {{20{w[31]}}, w[31:25], w[11:7]}; end
      7'b1100011: begin
        fmt = IMM_B; imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      end
      default: begin fmt = IMM_R; imm = 32'd0; end
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [31:0] w);
    logic [6:0] legal [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                               7'b0000011, 7'b0010011, 7'b1110011, 7'b0100011,
                               7'b1100011, 7'b0110011, 7'b0001111};
    logic ok = 1'b0;
    foreach (legal[i]) if (w[6:0] == legal[i]) ok = 1'b1;
    return (w[1:0] != 2'b11) || !ok;
  endfunction

  // Compare every observable against the model queue.
  task automatic check_all(input string tag);
    logic [2:0]  fmt;
    logic [31:0] imm;
    chk({tag, ".count"}, bus.count_o, q.size());
    chk({tag, ".in_ready"}, bus.in_ready_o, q.size() < DEPTH);
    chk({tag, ".out_valid"}, bus.out_valid_o, q.size() != 0);
    if (q.size() != 0) begin
      ref_dec(q[0].instr, fmt, imm);
      chk({tag, ".pc"}, bus.pc_o, q[0].pc);
      chk({tag, ".rd"}, bus.rd_addr_o, q[0].instr[11:7]);
      chk({tag, ".rs1"}, bus.rs1_addr_o, q[0].instr[19:15]);
      chk({tag, ".rs2"}, bus.rs2_addr_o, q[0].instr[24:20]);
      chk({tag, ".f3"}, bus.func3_o, q[0].instr[14:12]);
      chk({tag, ".f7"}, bus.func7_o, q[0].instr[31:25]);
      chk({tag, ".op"}, bus.opcode_o, q[0].instr[6:0]);
      chk({tag, ".fmt"}, bus.imm_fmt_o, fmt);
      chk({tag, ".imm"}, bus.imm_o, imm);
`ifdef CP_ILLEGAL_CHECK_EN
      chk({tag, ".illegal"}, bus.illegal_o, ref_illegal(q[0].instr));
`endif
    end
  endtask

  // One clock: model decides push/pop from inputs seen at the edge.
  task automatic step();
    bit   do_push, do_pop, clr;
    ent_t e;
    do_push = bus.in_valid_i && (q.size() < DEPTH);
    do_pop  = bus.out_ready_i && (q.size() > 0);
    clr     = rst || flush;
    e.instr = bus.instr_data_i;
    e.pc    = bus.pc_i;
    @(posedge clk);
    #1;
    if (clr) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input logic [31:0] pc);
    bus.in_valid_i   = 1'b1;
    bus.instr_data_i = w;
    bus.pc_i         = pc;
    step();
    bus.in_valid_i   = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready_i = 1'b1;
    step();
    bus.out_ready_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                             7'b0000011, 7'b0010011, 7'b1110011, 7'b0100011,
                             7'b1100011, 7'b0110011, 7'b0001111, 7'b0101011};
    logic [31:0] w = $urandom;
    if ($urandom_range(9) < 8) w[6:0] = ops[$urandom_range(11)];
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.instr_data_i = 32'd0;
    bus.pc_i = 32'd0;
    step();
    step();
    chk("rst.count", bus.count_o, 0);
    chk("rst.in_ready", bus.in_ready_o, 1);
    chk("rst.out_valid", bus.out_valid_o, 0);
    rst = 1'b0;

    push_word(32'hFFF10093, 32'h100);
    chk("addi.valid", bus.out_valid_o, 1);
    chk("addi.rd", bus.rd_addr_o, 1);
    chk("addi.rs1", bus.rs1_addr_o, 2);
    chk("addi.fmt", bus.imm_fmt_o, IMM_I);
    chk("addi.imm", bus.imm_o, 32'hFFFFFFFF);
    check_all("addi");
    pop_one();

    push_word(32'hFE000EE3, 32'h104);
    chk("beq.fmt", bus.imm_fmt_o, IMM_B);
    chk("beq.imm", bus.imm_o, 32'hFFFFFFFC);
    pop_one();
    push_word(32'h00512423, 32'h108);
    chk("sw.fmt", bus.imm_fmt_o, IMM_S);
    chk("sw.imm", bus.imm_o, 32'h8);
    chk("sw.rs2", bus.rs2_addr_o, 5);
    pop_one();
    push_word(32'h123450B7, 32'h10C);
    chk("lui.fmt", bus.imm_fmt_o, IMM_U);
    chk("lui.imm", bus.imm_o, 32'h12345000);
    pop_one();
    chk("empty.valid", bus.out_valid_o, 0);

    push_word(32'h00000000, 32'h110);
`ifdef CP_ILLEGAL_CHECK_EN
    chk("zero.illegal", bus.illegal_o, 1);
`endif
    check_all("zero");
    pop_one();

    // Fill DEPTH=2 with the consumer stalled, third word waits upstream.
    bus.in_valid_i = 1'b1;
    bus.instr_data_i = 32'h00A00513; bus.pc_i = 32'h200; step();
    bus.instr_data_i = 32'h00B00593; bus.pc_i = 32'h204; step();
    chk("full.count", bus.count_o, 2);
    chk("full.in_ready", bus.in_ready_o, 0);
    bus.instr_data_i = 32'h00C00613; bus.pc_i = 32'h208; step();
    chk("full.hold_count", bus.count_o, 2);
    chk("full.head", bus.pc_o, 32'h200);
    bus.out_ready_i = 1'b1;
    step();
    chk("drain.head1", bus.pc_o, 32'h204);
    chk("drain.count1", bus.count_o, 1);
    step();
    chk("drain.head2", bus.pc_o, 32'h208);
    bus.in_valid_i = 1'b0;
    step();
    chk("drain.empty", bus.count_o, 0);
    bus.out_ready_i = 1'b0;

    // Flush with a simultaneous push drops both.
    push_word(32'h00100093, 32'h300);
    bus.in_valid_i = 1'b1;
    bus.instr_data_i = 32'h00200113; bus.pc_i = 32'h304;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("flush.count", bus.count_o, 0);
    chk("flush.valid", bus.out_valid_o, 0);
    step();
    chk("flush.after", bus.out_valid_o, 0);

    // Reset mid-operation, together with flush and push.
    push_word(32'h00300193, 32'h400);
    push_word(32'h00400213, 32'h404);
    bus.in_valid_i = 1'b1;
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; bus.in_valid_i = 1'b0;
    chk("midrst.count", bus.count_o, 0);
    chk("midrst.in_ready", bus.in_ready_o, 1);
    step();
    chk("midrst.valid", bus.out_valid_o, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid_i   = ($urandom_range(99) < 60);
      bus.out_ready_i  = ($urandom_range(99) < 55);
      bus.instr_data_i = rand_instr();
      bus.pc_i         = $urandom;
      flush            = ($urandom_range(99) < 4);
      rst              = ($urandom_range(99) < 2);
      step();
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
